decode_issue_stage: RTL and testbench

- Decode/issue stage directly upstream of register_file.
- Accepts RV32I instructions from fetch over a valid/ready handshake and drives register_file read addresses.
- Tracks pending destination writes in a 32-entry busy scoreboard and stalls on RAW/WAW hazards, bypassing same-cycle writeback data.
- Registers the instruction plus both operands for execute behind a second valid/ready handshake.

---
 rtl/rv32i_pkg.sv | 23 ++
 rtl/issue_scoreboard.sv | 46 ++++
 rtl/decode_issue_stage.sv | 137 +++++++++++++
 tb/tb_decode_issue_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// RV32I decode constants shared by the decode/issue slice:
// major opcodes and instruction field positions.
package rv32i_pkg;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OPIMM  = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  localparam int unsigned OPC_LSB = 0;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned RD_LSB  = 7;
  localparam int unsigned RS1_LSB = 15;
  localparam int unsigned RS2_LSB = 20;

endpackage

// File: rtl/issue_scoreboard.sv
// Busy-bit scoreboard for pending register writes. Set beats clear on the
// same register; lookups already account for this cycle's writeback clear.
module issue_scoreboard #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_set_en,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr_en,
  input  logic [AW-1:0] i_clr_addr,
  input  logic          i_fclr_en,
  input  logic [AW-1:0] i_fclr_addr,
  input  logic [AW-1:0] i_rs1_addr,
  input  logic [AW-1:0] i_rs2_addr,
  input  logic [AW-1:0] i_rd_addr,
  output logic          o_rs1_busy,
  output logic          o_rs2_busy,
  output logic          o_rd_busy
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_en)  w_busy_next[i_clr_addr]  = 1'b0;
    if (i_fclr_en) w_busy_next[i_fclr_addr] = 1'b0;
    if (i_set_en)  w_busy_next[i_set_addr]  = 1'b1;
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_busy <= '0;
    else       r_busy <= w_busy_next;
  end

  assign o_rs1_busy = (i_rs1_addr != '0) && r_busy[i_rs1_addr] &&
                      !(i_clr_en && (i_clr_addr == i_rs1_addr));
  assign o_rs2_busy = (i_rs2_addr != '0) && r_busy[i_rs2_addr] &&
                      !(i_clr_en && (i_clr_addr == i_rs2_addr));
  assign o_rd_busy  = (i_rd_addr != '0) && r_busy[i_rd_addr] &&
                      !(i_clr_en && (i_clr_addr == i_rd_addr));

endmodule

// File: rtl/decode_issue_stage.sv
// RV32I decode/issue stage: source decode, RAW/WAW stall against the busy
// scoreboard, writeback bypass, and a registered handoff to execute.
module decode_issue_stage
  import rv32i_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_instr,
  input  logic [XLEN-1:0]          in_pc,
  output logic [$clog2(NREG)-1:0]  rf_read_addr_1,
  output logic [$clog2(NREG)-1:0]  rf_read_addr_2,
  input  logic [XLEN-1:0]          rf_read_data_1,
  input  logic [XLEN-1:0]          rf_read_data_2,
  input  logic                     wb_valid,
  input  logic [$clog2(NREG)-1:0]  wb_addr,
  input  logic [XLEN-1:0]          wb_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_instr,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_rs1_data,
  output logic [XLEN-1:0]          out_rs2_data,
  output logic [$clog2(NREG)-1:0]  out_rd,
  output logic                     out_reg_write,
  output logic                     out_illegal
);

  localparam int unsigned AW = $clog2(NREG);

  logic [OPC_W-1:0] w_opc;
  logic [AW-1:0]    w_rd, w_rs1, w_rs2;
  logic             w_use1, w_use2, w_wcls, w_illegal, w_reg_write;
  logic             w_rs1_busy, w_rs2_busy, w_rd_busy, w_hazard, w_fire;
  logic [XLEN-1:0]  w_op1, w_op2;

  logic             r_valid, r_reg_write, r_illegal;
  logic [XLEN-1:0]  r_instr, r_pc, r_rs1_data, r_rs2_data;
  logic [AW-1:0]    r_rd;

  assign w_opc = in_instr[OPC_LSB +: OPC_W];
  assign w_rd  = in_instr[RD_LSB  +: AW];
  assign w_rs1 = in_instr[RS1_LSB +: AW];
  assign w_rs2 = in_instr[RS2_LSB +: AW];

  assign rf_read_addr_1 = w_rs1;
  assign rf_read_addr_2 = w_rs2;

  always_comb begin
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_wcls    = 1'b0;
    w_illegal = 1'b0;
    case (w_opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL:   w_wcls = 1'b1;
      OPC_JALR, OPC_LOAD, OPC_OPIMM: begin w_use1 = 1'b1; w_wcls = 1'b1; end
      OPC_OP:                        begin w_use1 = 1'b1; w_use2 = 1'b1; w_wcls = 1'b1; end
      OPC_BRANCH, OPC_STORE:         begin w_use1 = 1'b1; w_use2 = 1'b1; end
      default:                       w_illegal = 1'b1;
    endcase
  end

  assign w_reg_write = w_wcls && (w_rd != '0);

  // Unused sources read as zero so execute never sees immediate bits as data.
  always_comb begin
    w_op1 = '0;
    w_op2 = '0;
    if (w_use1 && (w_rs1 != '0))
      w_op1 = (wb_valid && (wb_addr == w_rs1)) ? wb_data : rf_read_data_1;
    if (w_use2 && (w_rs2 != '0))
      w_op2 = (wb_valid && (wb_addr == w_rs2)) ? wb_data : rf_read_data_2;
  end

  issue_scoreboard #(.NREG(NREG), .AW(AW)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_set_en   (w_fire && w_reg_write),
    .i_set_addr (w_rd),
    .i_clr_en   (wb_valid),
    .i_clr_addr (wb_addr),
    .i_fclr_en  (flush && r_valid && r_reg_write),
    .i_fclr_addr(r_rd),
    .i_rs1_addr (w_rs1),
    .i_rs2_addr (w_rs2),
    .i_rd_addr  (w_rd),
    .o_rs1_busy (w_rs1_busy),
    .o_rs2_busy (w_rs2_busy),
    .o_rd_busy  (w_rd_busy)
  );

  assign w_hazard = (w_use1 && w_rs1_busy) || (w_use2 && w_rs2_busy) ||
                    (w_reg_write && w_rd_busy);
  assign in_ready = !w_hazard && (!r_valid || out_ready) && !flush;
  assign w_fire   = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_instr     <= '0;
      r_pc        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_fire)    r_valid <= 1'b1;
      else if (out_ready) r_valid <= 1'b0;
      if (w_fire) begin
        r_instr     <= in_instr;
        r_pc        <= in_pc;
        r_rs1_data  <= w_op1;
        r_rs2_data  <= w_op2;
        r_rd        <= w_rd;
        r_reg_write <= w_reg_write;
        r_illegal   <= w_illegal;
      end
    end
  end

  assign out_valid     = r_valid;
  assign out_instr     = r_instr;
  assign out_pc        = r_pc;
  assign out_rs1_data  = r_rs1_data;
  assign out_rs2_data  = r_rs2_data;
  assign out_rd        = r_rd;
  assign out_reg_write = r_reg_write;
  assign out_illegal   = r_illegal;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios then randomized traffic,
// all checked against a pending-write-set model of the issue stage.
module tb_decode_issue_stage;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready, wb_valid;
  logic        in_ready, out_valid, out_reg_write, out_illegal;
  logic [31:0] in_instr, in_pc, rf_read_data_1, rf_read_data_2, wb_data;
  logic [31:0] out_instr, out_pc, out_rs1_data, out_rs2_data;
  logic [4:0]  rf_read_addr_1, rf_read_addr_2, wb_addr, out_rd;

  decode_issue_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rf_read_addr_1(rf_read_addr_1), .rf_read_addr_2(rf_read_addr_2),
    .rf_read_data_1(rf_read_data_1), .rf_read_data_2(rf_read_data_2),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Model: set of registers with a write in flight, plus the execute-side slot.
  bit        m_busy [32];
  bit        m_ov, m_rw, m_ill;
  bit [31:0] m_instr, m_pc, m_d1, m_d2;
  bit [4:0]  m_rd;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_ov = 0; m_rw = 0; m_ill = 0; m_instr = 0; m_pc = 0; m_d1 = 0; m_d2 = 0; m_rd = 0;
  endtask

  function automatic bit [3:0] classify(input bit [6:0] opc);
    // {uses rs1, uses rs2, writes rd, illegal}
    case (opc)
      7'b0110111, 7'b0010111, 7'b1101111: return 4'b0010;
      7'b1100111, 7'b0000011, 7'b0010011: return 4'b1010;
      7'b0110011:                         return 4'b1110;
      7'b1100011, 7'b0100011:             return 4'b1100;
      default:                            return 4'b0001;
    endcase
  endfunction

  function automatic bit [31:0] operand(input bit used, input bit [4:0] a, input bit [31:0] rfd);
    if (!used || a == 0) return 32'd0;
    if (wb_valid && wb_addr == a) return wb_data;
    return rfd;
  endfunction

  function automatic bit pending(input bit [4:0] a);
    return a != 0 && m_busy[a] && !(wb_valid && wb_addr == a);
  endfunction

  // One clock: inputs are already driven (just after a negedge).
  task automatic step();
    bit [3:0]  cls;
    bit [4:0]  rs1, rs2, rd;
    bit        wr, haz, rdy, fire;
    bit [31:0] d1, d2;
    #1;
    rs1 = in_instr[19:15]; rs2 = in_instr[24:20]; rd = in_instr[11:7];
    cls = classify(in_instr[6:0]);
    wr  = cls[1] && rd != 0;
    haz = (cls[3] && pending(rs1)) || (cls[2] && pending(rs2)) || (wr && pending(rd));
    rdy = !haz && (!m_ov || out_ready) && !flush;
    fire = in_valid && rdy;
    d1 = operand(cls[3], rs1, rf_read_data_1);
    d2 = operand(cls[2], rs2, rf_read_data_2);
    check("in_ready", in_ready, rdy);
    check("rf_addr1", rf_read_addr_1, rs1);
    check("rf_addr2", rf_read_addr_2, rs2);
    @(posedge clk);
    if (wb_valid) m_busy[wb_addr] = 1'b0;
    if (flush && m_ov && m_rw) m_busy[m_rd] = 1'b0;
    if (fire && wr) m_busy[rd] = 1'b1;
    if (flush)                   m_ov = 1'b0;
    else if (fire)               m_ov = 1'b1;
    else if (m_ov && out_ready)  m_ov = 1'b0;
    if (fire) begin
      m_instr = in_instr; m_pc = in_pc; m_d1 = d1; m_d2 = d2;
      m_rd = rd; m_rw = wr; m_ill = cls[0];
    end
    #1;
    check("out_valid", out_valid, m_ov);
    check("out_instr", out_instr, m_instr);
    check("out_pc", out_pc, m_pc);
    check("out_rs1_data", out_rs1_data, m_d1);
    check("out_rs2_data", out_rs2_data, m_d2);
    check("out_rd", out_rd, m_rd);
    check("out_reg_write", out_reg_write, m_rw);
    check("out_illegal", out_illegal, m_ill);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input bit [31:0] ins, input bit ordy,
                       input bit wbv, input bit [4:0] wba, input bit [31:0] wbd);
    in_valid = v; in_instr = ins; in_pc = in_pc + 32'd4; out_ready = ordy;
    wb_valid = wbv; wb_addr = wba; wb_data = wbd;
    rf_read_data_1 = $urandom; rf_read_data_2 = $urandom;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_instr"}, out_instr, 0);
    check({tag, "_pc"}, out_pc, 0);
    check({tag, "_rs1"}, out_rs1_data, 0);
    check({tag, "_rs2"}, out_rs2_data, 0);
    check({tag, "_rd"}, out_rd, 0);
    check({tag, "_rw"}, out_reg_write, 0);
    check({tag, "_ill"}, out_illegal, 0);
  endtask

  localparam bit [6:0] OPCS [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                                     7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                                     7'b0110011, 7'b1111111};

  initial begin
    bit [31:0] ins;
    bit [4:0]  busy_q [$];
    bit [4:0]  wba;
    reset = 1'b1; flush = 0; in_valid = 0; out_ready = 0; wb_valid = 0;
    in_instr = 0; in_pc = 32'h100; wb_addr = 0; wb_data = 0;
    rf_read_data_1 = 0; rf_read_data_2 = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;

    // ADDI x1,x0,5
    drive(1, 32'h00500093, 1, 0, 0, 0); step();
    check("addi_valid", out_valid, 1);
    check("addi_rd", out_rd, 1);
    check("addi_rw", out_reg_write, 1);
    // ADD x2,x1,x1 stalls on busy x1, then issues with the bypassed writeback
    drive(1, 32'h00108133, 1, 0, 0, 0); step();
    check("raw_stall_valid", out_valid, 0);
    drive(1, 32'h00108133, 1, 1, 1, 32'd5); step();
    check("bypass_rs1", out_rs1_data, 5);
    check("bypass_rs2", out_rs2_data, 5);
    // ADDI x4 issues, then ADDI x5 waits three cycles behind a stalled consumer
    drive(1, 32'h00700213, 1, 0, 0, 0); step();
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1, 32'h00800293, 0, 0, 0, 0); step();
      check("hold_instr", out_instr, 32'h00700213);
    end
    drive(1, 32'h00800293, 1, 0, 0, 0); step();
    check("resume_instr", out_instr, 32'h00800293);
    drive(0, 32'h00000013, 1, 0, 0, 0); step();
    check("drain_valid", out_valid, 0);
    // WAW on x3 resolved by a flush of the held writer
    drive(1, 32'h00100193, 0, 0, 0, 0); step();
    drive(1, 32'h00200193, 0, 0, 0, 0); step();
    flush = 1; drive(1, 32'h00200193, 0, 0, 0, 0); step();
    check("flush_valid", out_valid, 0);
    flush = 0; drive(1, 32'h00200193, 1, 0, 0, 0); step();
    check("waw_issue", out_instr, 32'h00200193);
    // Retire x4 and x5, then SW x5,0(x6)
    drive(0, 32'h0, 1, 1, 4, 0); step();
    drive(0, 32'h0, 1, 1, 5, 0); step();
    drive(1, 32'h00532023, 1, 0, 0, 0);
    rf_read_data_1 = 32'hDEADBEEF; rf_read_data_2 = 32'h00001234; step();
    check("sw_rs1", out_rs1_data, 32'hDEADBEEF);
    check("sw_rs2", out_rs2_data, 32'h00001234);
    check("sw_rw", out_reg_write, 0);
    // Illegal opcode whose rd field names busy x3: must not stall
    drive(1, 32'h001081FF, 1, 0, 0, 0); step();
    check("ill_flag", out_illegal, 1);
    check("ill_valid", out_valid, 1);
    // Asynchronous reset in the middle of a RAW stall on x1
    drive(1, 32'h00500093, 1, 0, 0, 0); step();
    drive(1, 32'h00108133, 1, 0, 0, 0);
    #2 reset = 1'b1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1, 32'h00108133, 1, 0, 0, 0); step();
    check("post_rst_issue", out_instr, 32'h00108133);

    // Randomized traffic over a small register window to provoke hazards
    for (int unsigned n = 0; n < 3000; n++) begin
      ins = $urandom;
      ins[6:0]   = OPCS[$urandom_range(0, 9)];
      ins[11:7]  = 5'($urandom_range(0, 7));
      ins[19:15] = 5'($urandom_range(0, 7));
      ins[24:20] = 5'($urandom_range(0, 7));
      busy_q.delete();
      for (int unsigned r = 1; r < 32; r++) if (m_busy[r]) busy_q.push_back(5'(r));
      wba = 5'($urandom_range(0, 7));
      if (busy_q.size() > 0 && $urandom_range(0, 3) != 0)
        wba = busy_q[$urandom_range(0, busy_q.size() - 1)];
      flush = ($urandom_range(0, 19) == 0);
      drive($urandom_range(0, 3) != 0, ins, $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 4, wba, $urandom);
      step();
    end
    flush = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
